// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Serial UART transmitter. Accepts one word per valid/ready
//            handshake and sends start bit, 5..8 data bits LSB first,
//            optional even parity and 1 or 2 stop bits. Bit period is
//            cfg_div_i+1 clocks, shared with the receiver.
// Options  : UART_TX_PARITY_EN - when defined, the parity bit and
//            cfg_parity_en_i are honoured; otherwise frames never carry
//            a parity bit and cfg_parity_en_i is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_en_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic        tx_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA      = 3'd2,
        STOP_BIT  = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY    = 3'd4
`endif
    } state_t;

    state_t      state_q,    state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [15:0] div_q,      div_d;
    logic [1:0]  bits_q,     bits_d;
    logic        stop2_q,    stop2_d;
    logic        tx_q,       tx_d;
`ifdef UART_TX_PARITY_EN
    logic        par_en_q,   par_en_d;
    logic        parity_q,   parity_d;
`else
    // Parity disabled at build time: the enable input is deliberately unused.
    logic        w_unused_parity_en;
    assign w_unused_parity_en = cfg_parity_en_i;
`endif

    logic        bit_end;
    logic [2:0]  last_bit;

    assign bit_end  = (baud_cnt_q == div_q);
    // Index of the final data bit: width code 0..3 maps to bits 4..7.
    assign last_bit = {1'b0, bits_q} + 3'd4;

    // Ready depends only on state and enable, never on tx_valid_i.
    assign tx_ready_o = (state_q == IDLE) && cfg_en_i && !rst_i;
    assign busy_o     = (state_q != IDLE);
    assign tx_o       = tx_q;

    // Next-state, counters, latched frame configuration and next line level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
        bits_d     = bits_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (tx_valid_i && tx_ready_o) begin
                    shift_d    = tx_data_i;
                    div_d      = cfg_div_i;
                    bits_d     = cfg_bits_i;
                    stop2_d    = cfg_stop_bits_i;
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = cfg_parity_en_i;
                    parity_d   = 1'b0;
`endif
                    state_d    = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b1, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
                    parity_d   = parity_q ^ shift_q[0];
`endif
                    if (bit_cnt_q == last_bit) begin
                        bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = par_en_q ? PARITY : STOP_BIT;
`else
                        state_d   = STOP_BIT;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    state_d    = STOP_BIT;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_end) begin
                    baud_cnt_d = 16'd0;
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 3'd0;
                stop_cnt_d = 1'b0;
            end
        endcase

        // Disabling aborts any frame immediately; the word is dropped.
        if (!cfg_en_i) begin
            state_d    = IDLE;
            baud_cnt_d = 16'd0;
            bit_cnt_d  = 3'd0;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = 1'b0;
`endif
        end

        // Line level is registered, so it is derived from the next state.
        case (state_d)
            START_BIT: tx_d = 1'b0;
            DATA:      tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:    tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'hFF;
            div_q      <= 16'd0;
            bits_q     <= 2'd0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            parity_q   <= parity_d;
`endif
        end
    end

endmodule
`default_nettype wire
